edge_counter: RTL and testbench

- Single-channel edge/timing measurement engine. Two instances feed the SCARF edge-counter regmap with d1/d2/d3 counts.
- It takes its per-channel enable, trigger-enable, input-invert and trigger-out configuration bits from that regmap.
- It measures three intervals on an asynchronous input in clk cycles:
  - d1: start to first rising edge.
  - d2: high time.
  - d3: low time.
- It can emit a trigger pulse to start the sibling channel.

---
 rtl/edge_counter.sv | 115 +++++++++++
 tb/tb_edge_counter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_counter.sv
// Single-channel edge/timing measurement engine: measures start-to-first-rise (d1),
// high time (d2) and low time (d3) of an asynchronous input, in clk cycles.
module edge_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_sync,
    input  logic                 sig_in,
    input  logic                 trig_in,
    input  logic                 enable,
    input  logic                 trig_enable,
    input  logic                 cfg_in_inv,
    input  logic                 cfg_trig_out,
    output logic                 trig_out,
    output logic [CNT_WIDTH-1:0] d1_count,
    output logic [CNT_WIDTH-1:0] d2_count,
    output logic [CNT_WIDTH-1:0] d3_count,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TRIG,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW,
        DONE
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   enable_q;
    logic                   trig_out_q;
    logic [CNT_WIDTH-1:0]   d1_q, d2_q, d3_q;
    logic [CNT_WIDTH-1:0]   d1_d, d2_d, d3_d;
    logic                   s, rise, fall, arm;

    assign s    = sync_q[SYNC_STAGES-1] ^ cfg_in_inv;
    assign rise = s & ~s_prev_q;
    assign fall = ~s & s_prev_q;
    assign arm  = enable & ~enable_q;

    // Saturating increments: counts stick at all-ones instead of wrapping.
    always_comb begin
        d1_d = (d1_q == '1) ? d1_q : d1_q + CNT_WIDTH'(1);
        d2_d = (d2_q == '1) ? d2_q : d2_q + CNT_WIDTH'(1);
        d3_d = (d3_q == '1) ? d3_q : d3_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            s_prev_q   <= 1'b0;
            enable_q   <= 1'b0;
            trig_out_q <= 1'b0;
            d1_q       <= '0;
            d2_q       <= '0;
            d3_q       <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_prev_q   <= s;
            enable_q   <= enable;
            trig_out_q <= 1'b0;
            // Dropping enable outside IDLE aborts at once and keeps partial counts.
            if (state_q != IDLE && !enable) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (arm) begin
                            d1_q    <= '0;
                            d2_q    <= '0;
                            d3_q    <= '0;
                            state_q <= trig_enable ? WAIT_TRIG : WAIT_RISE;
                        end
                    end
                    WAIT_TRIG: begin
                        if (trig_in) state_q <= WAIT_RISE;
                    end
                    WAIT_RISE: begin
                        d1_q <= d1_d;
                        if (rise) begin
                            state_q    <= MEAS_HIGH;
                            trig_out_q <= cfg_trig_out;
                        end
                    end
                    MEAS_HIGH: begin
                        d2_q <= d2_d;
                        if (fall) state_q <= MEAS_LOW;
                    end
                    MEAS_LOW: begin
                        d3_q <= d3_d;
                        if (rise) state_q <= DONE;
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign trig_out = trig_out_q;
    assign d1_count = d1_q;
    assign d2_count = d2_q;
    assign d3_count = d3_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_edge_counter.sv
// Scoreboard bench for edge_counter: expected counts come from an interval model of
// the driven waveform and are checked when each instance reaches DONE.
module tb_edge_counter;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_sync = 1'b1;
    logic sig_in = 1'b0;
    logic trig_in = 1'b0;
    logic enable = 1'b0;
    logic trig_enable = 1'b0;
    logic cfg_in_inv = 1'b0;
    logic cfg_trig_out = 1'b0;
    logic use_s = 1'b0;

    logic        a_trig_out, a_busy, a_done;
    logic [31:0] a_d1, a_d2, a_d3;
    logic        b_trig_out, b_busy, b_done;
    logic [31:0] b_d1, b_d2, b_d3;
    logic        s_trig_out, s_busy, s_done;
    logic [3:0]  s_d1, s_d2, s_d3;

    edge_counter #(.SYNC_STAGES(SYNC), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst_sync(rst_sync), .sig_in(sig_in), .trig_in(trig_in),
        .enable(enable), .trig_enable(trig_enable), .cfg_in_inv(cfg_in_inv),
        .cfg_trig_out(cfg_trig_out), .trig_out(a_trig_out), .d1_count(a_d1),
        .d2_count(a_d2), .d3_count(a_d3), .busy(a_busy), .done(a_done)
    );

    edge_counter #(.SYNC_STAGES(SYNC), .CNT_WIDTH(32)) dut_b (
        .clk(clk), .rst_sync(rst_sync), .sig_in(sig_in), .trig_in(a_trig_out),
        .enable(enable), .trig_enable(1'b1), .cfg_in_inv(cfg_in_inv),
        .cfg_trig_out(1'b0), .trig_out(b_trig_out), .d1_count(b_d1),
        .d2_count(b_d2), .d3_count(b_d3), .busy(b_busy), .done(b_done)
    );

    edge_counter #(.SYNC_STAGES(SYNC), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst_sync(rst_sync), .sig_in(sig_in), .trig_in(1'b0),
        .enable(enable & use_s), .trig_enable(trig_enable), .cfg_in_inv(cfg_in_inv),
        .cfg_trig_out(1'b0), .trig_out(s_trig_out), .d1_count(s_d1),
        .d2_count(s_d2), .d3_count(s_d3), .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint d1;
        longint d2;
        longint d3;
        int     r;
    } exp_t;

    int   n_total = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   arm_cyc = 0;
    int   tp_count = 0;
    int   tp_cyc = 0;
    bit   pat[$];
    exp_t qa[$], qb[$], qs[$];
    logic a_done_prev = 1'b0, b_done_prev = 1'b0, s_done_prev = 1'b0;

    task automatic check_val(input string tag, input longint obs, input longint exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Interval model over stage-1 samples; a rise seen by the FSM at edge e+SYNC
    // only counts when it lands after the start edge s.
    function automatic exp_t model(input bit inv, input int s, input int w);
        exp_t   r;
        int     r1 = -1, f = -1, r2 = -1;
        bit     prev, x;
        longint sat;
        sat  = (longint'(1) << w) - 1;
        prev = pat[0] ^ inv;
        for (int e = 0; e < pat.size(); e++) begin
            x = pat[e] ^ inv;
            if (r1 < 0) begin
                if (x && !prev && (e + SYNC > s)) r1 = e;
            end else if (f < 0) begin
                if (!x && prev) f = e;
            end else if (r2 < 0) begin
                if (x && !prev) r2 = e;
            end
            prev = x;
        end
        r.d1 = (r1 < 0) ? -1 : longint'(r1 + SYNC - s);
        r.d2 = (f < 0)  ? -1 : longint'(f - r1);
        r.d3 = (r2 < 0) ? -1 : longint'(r2 - f);
        if (r.d1 > sat) r.d1 = sat;
        if (r.d2 > sat) r.d2 = sat;
        if (r.d3 > sat) r.d3 = sat;
        r.r = r1 + SYNC;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (a_trig_out) begin
            tp_count++;
            tp_cyc = cyc;
        end
        if (a_done && !a_done_prev) begin
            if (qa.size() == 0) check_val("a_unexp_done", a_done, 0);
            else begin
                e = qa.pop_front();
                check_val("a_d1", a_d1, e.d1);
                check_val("a_d2", a_d2, e.d2);
                check_val("a_d3", a_d3, e.d3);
                check_val("a_busy", a_busy, 0);
            end
        end
        if (b_done && !b_done_prev) begin
            if (qb.size() == 0) check_val("b_unexp_done", b_done, 0);
            else begin
                e = qb.pop_front();
                check_val("b_d1", b_d1, e.d1);
                check_val("b_d2", b_d2, e.d2);
                check_val("b_d3", b_d3, e.d3);
            end
        end
        if (s_done && !s_done_prev) begin
            if (qs.size() == 0) check_val("s_unexp_done", s_done, 0);
            else begin
                e = qs.pop_front();
                check_val("s_d1", s_d1, e.d1);
                check_val("s_d2", s_d2, e.d2);
                check_val("s_d3", s_d3, e.d3);
            end
        end
        a_done_prev = a_done;
        b_done_prev = b_done;
        s_done_prev = s_done;
    end

    task automatic add(input bit v, input int n);
        repeat (n) pat.push_back(v);
    endtask

    // Leaves the channel idle with the line settled, then raises enable on a negedge
    // so the following posedge is the arm edge (edge 0).
    task automatic prep(input bit inv, input bit tre, input bit tro);
        enable       = 1'b0;
        trig_in      = 1'b0;
        cfg_in_inv   = inv;
        trig_enable  = tre;
        cfg_trig_out = tro;
        sig_in       = pat[0];
        repeat (5) @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic drive(input int n_edges, input int trig_at);
        for (int e = 0; e < n_edges; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 0) arm_cyc = cyc;
            if (trig_at > 0 && e + 1 == trig_at) check_val("pre_trig_d1", a_d1, 0);
            sig_in  = pat[(e + 1 < pat.size()) ? e + 1 : pat.size() - 1];
            trig_in = (e + 1 == trig_at);
        end
        trig_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (qa.size() + qb.size() + qs.size()) != 0; i++)
            @(negedge clk);
        #1;
        check_val("drain", qa.size() + qb.size() + qs.size(), 0);
    endtask

    initial begin
        exp_t ea, eb;
        int   tp0;
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ea, eb;
        int   tp0;

        repeat (3) @(negedge clk);
        check_val("rst_d1", a_d1, 0);
        check_val("rst_d2", a_d2, 0);
        check_val("rst_d3", a_d3, 0);
        check_val("rst_busy", a_busy, 0);
        check_val("rst_done", a_done, 0);
        check_val("rst_trig_out", a_trig_out, 0);
        rst_sync = 1'b0;

        // Basic measurement, no trigger, trig_out disabled.
        pat.delete();
        add(0, 10); add(1, 7); add(0, 5); add(1, 4); add(0, 6); add(1, 4);
        qa.push_back(model(1'b0, 0, 32));
        prep(1'b0, 1'b0, 1'b0);
        tp0 = tp_count;
        drive(pat.size(), 0);
        drain();
        check_val("t1_no_trig_out", tp_count - tp0, 0);
        check_val("t1_done_level", a_done, 1);

        // Same waveform, inverted input.
        qa.push_back(model(1'b1, 0, 32));
        prep(1'b1, 1'b0, 1'b0);
        drive(pat.size(), 0);
        drain();

        // Trigger-started: toggling before trig_in, trig coincident with a rise.
        pat.delete();
        for (int e = 0; e < 66; e++) pat.push_back((e % 6) < 3);
        qa.push_back(model(1'b0, 50, 32));
        prep(1'b0, 1'b1, 1'b0);
        drive(pat.size(), 50);
        drain();

        // Chained: A.trig_out starts B.
        pat.delete();
        add(0, 5); add(1, 4); add(0, 3); add(1, 6); add(0, 4); add(1, 5); add(0, 3);
        ea = model(1'b0, 0, 32);
        eb = model(1'b0, ea.r + 1, 32);
        qa.push_back(ea);
        qb.push_back(eb);
        prep(1'b0, 1'b0, 1'b1);
        tp0 = tp_count;
        drive(pat.size(), 0);
        drain();
        check_val("chain_pulses", tp_count - tp0, 1);
        check_val("chain_pulse_edge", tp_cyc - arm_cyc, ea.r);

        // Saturation on a 4-bit instance alongside the 32-bit one.
        pat.delete();
        add(0, 30); add(1, 3); add(0, 3); add(1, 4);
        use_s = 1'b1;
        qa.push_back(model(1'b0, 0, 32));
        qs.push_back(model(1'b0, 0, 4));
        prep(1'b0, 1'b0, 1'b0);
        drive(pat.size(), 0);
        drain();
        use_s = 1'b0;

        // Abort in MEAS_HIGH with d2=3, then re-arm.
        pat.delete();
        add(0, 3); add(1, 20);
        prep(1'b0, 1'b0, 1'b0);
        drive(9, 0);
        check_val("abort_pre_d2", a_d2, 3);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_d2", a_d2, 3);
        check_val("abort_d1", a_d1, 5);
        check_val("abort_busy", a_busy, 0);
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("rearm_d1", a_d1, 0);
        check_val("rearm_d2", a_d2, 0);
        check_val("rearm_d3", a_d3, 0);
        check_val("rearm_busy", a_busy, 1);

        // Reset in MEAS_LOW.
        pat.delete();
        add(0, 3); add(1, 4); add(0, 20);
        prep(1'b0, 1'b0, 1'b1);
        drive(13, 0);
        check_val("mrst_pre_d3", a_d3, 3);
        rst_sync = 1'b1;
        enable   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("mrst_d1", a_d1, 0);
        check_val("mrst_d2", a_d2, 0);
        check_val("mrst_d3", a_d3, 0);
        check_val("mrst_busy", a_busy, 0);
        check_val("mrst_done", a_done, 0);
        check_val("mrst_trig_out", a_trig_out, 0);
        rst_sync = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
